fifo_stream_drain: RTL

//  Read-side drain stage that sits directly downstream of sync_circular_fifo.

---
 rtl/fifo_stream_drain_if.sv | 26 ++
 rtl/fifo_stream_drain.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_stream_drain_if.sv
// Purpose : handshake bundle between fifo_stream_drain, its FIFO and its stream consumer.
// Ports   : FIFO read side (enable, empty, data, rd_en), stream side (valid, data, ready),
//           accepted-beat counter. 'master' is the drain's view, 'slave' the environment's.
interface fifo_stream_drain_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
);
  logic                   enable_i;
  logic                   fifo_empty_i;
  logic [DATA_WIDTH-1:0]  fifo_data_i;
  logic                   fifo_rd_en_o;
  logic                   m_valid_o;
  logic [DATA_WIDTH-1:0]  m_data_o;
  logic                   m_ready_i;
  logic [COUNT_WIDTH-1:0] beat_count_o;

  modport master (
    input  enable_i, fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, beat_count_o
  );

  modport slave (
    output enable_i, fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, beat_count_o
  );
endinterface

// File: rtl/fifo_stream_drain.sv
// Purpose : pops a 1-cycle-latency sync FIFO and presents words on a valid/ready stream via a 2-entry skid buffer.
// Latency : rd_en sampled at edge N -> word captured into head at edge N+1 -> m_valid_o high after that edge.
// Backpr. : reads are credit-limited to the 2 buffer slots; with m_ready_i low at most 2 words are pulled.
// Ports   : clk_i, rst_i (sync, active-high); bus (master modport) carries enable_i, fifo_empty_i,
//           fifo_data_i, fifo_rd_en_o, m_valid_o, m_data_o, m_ready_i, beat_count_o.
module fifo_stream_drain #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_stream_drain_if.master  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  spare_q, spare_d;
  logic                   inflight_q, inflight_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic       pop;
  logic       arrive;
  logic       rd_en;
  logic [2:0] slots_used;

  assign pop    = (state_q != S_EMPTY) & bus.m_ready_i;
  // A read issued last cycle delivers its word on fifo_data_i this cycle.
  assign arrive = inflight_q;

  // Slots committed after this edge: buffered + returning - leaving. Pop can only
  // happen with occupancy >= 1, so this never underflows. The combinational path
  // from m_ready_i lets a slot freed this cycle be refilled immediately.
  assign slots_used = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Gated by reset so no FIFO word is popped and then thrown away during reset.
  assign rd_en = ~rst_i & bus.enable_i & ~bus.fifo_empty_i & (slots_used < 3'd2);

  assign inflight_d = rd_en;
  assign count_d    = count_q + COUNT_WIDTH'(pop);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    spare_d = spare_q;
    unique case (state_q)
      S_EMPTY: begin
        if (arrive) begin
          head_d  = bus.fifo_data_i;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (arrive && !pop) begin
          spare_d = bus.fifo_data_i;
          state_d = S_TWO;
        end else if (arrive && pop) begin
          head_d  = bus.fifo_data_i;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          head_d  = spare_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      spare_q    <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      spare_q    <= spare_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = (state_q != S_EMPTY);
  // head_q is only rewritten on arrive/pop, so data holds while valid is low.
  assign bus.m_data_o     = head_q;
  assign bus.beat_count_o = count_q;

  // The read credit rule makes a word arriving into a full buffer impossible.
  a_no_arrive_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i) !((state_q == S_TWO) && inflight_q)
  );

endmodule
